// File: rtl/video_pkg.sv
// Shared timing definitions for the raster generator.
// Holds the per-axis state enum, the 640x480@60 default segment lengths,
// and a helper that sums the four segments of an axis into its total.
package video_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned MAX_TOTAL = 2048;
  localparam int unsigned CNT_W     = 11;

  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle of the timing generator.
//   master: drives counts, de, syncs, pulses and frame counter
//   slave : consumes them (sprite/overlay stages, TMDS encoder)
interface video_timing_gen_if;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output hcnt, vcnt, de, hsync, vsync, line_start, frame_start, frame_cnt
  );

  modport slave (
    input hcnt, vcnt, de, hsync, vsync, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/video_axis_timer.sv
// One raster axis: a counter over [0, TOTAL) with its segment state.
//   clk, resetn : pixel clock, synchronous active-low reset
//   i_step      : advance the count by one (wrapping at TOTAL-1)
//   o_cnt       : current count
//   o_state     : segment the current count lies in
//   o_wrap      : count is at TOTAL-1, so the next step wraps to 0
// Reset parks the axis at TOTAL-1 in BACK so the first step lands on 0.
module video_axis_timer
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_step,
  output logic [CNT_W-1:0]   o_cnt,
  output axis_state_e        o_state,
  output logic               o_wrap
);

  localparam int unsigned TOTAL = calc_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > MAX_TOTAL || TOTAL == 0) begin : g_bad_total
    $error("video_axis_timer: TOTAL %0d outside 1..%0d", TOTAL, MAX_TOTAL);
  end

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   B_FRONT = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0]   B_SYNC  = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0]   B_BACK  = (CNT_W+1)'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  axis_state_e      state_q, state_d;

  // State is chosen from the range the next count falls in, so segments of
  // zero length are simply skipped rather than stalling the sequence.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (i_step) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      if ({1'b0, cnt_d} < B_FRONT)     state_d = ST_ACTIVE;
      else if ({1'b0, cnt_d} < B_SYNC) state_d = ST_FRONT;
      else if ({1'b0, cnt_d} < B_BACK) state_d = ST_SYNC;
      else                             state_d = ST_BACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= LAST;
      state_q <= ST_BACK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign o_cnt   = cnt_q;
  assign o_state = state_q;
  assign o_wrap  = (cnt_q == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator for the HDMI output path.
//   clk, resetn   : pixel clock, synchronous active-low reset
//   i_enable      : pixel-advance enable; low holds all state
//   o_hcnt/o_vcnt : zero-based raster position (0,0 = top-left active pixel)
//   o_de          : active-video data enable
//   o_hsync/o_vsync : syncs at HS_POL/VS_POL level while in SYNC segment
//   o_line_start  : one-cycle pulse when o_hcnt becomes 0
//   o_frame_start : one-cycle pulse when both counts become 0
//   o_frame_cnt   : frames started since reset, wrapping
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_enable,
  output logic [10:0] o_hcnt,
  output logic [10:0] o_vcnt,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
);

  axis_state_e h_state, v_state;
  logic        h_wrap, v_wrap;
  logic        v_step;

  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  video_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .resetn  (resetn),
    .i_step  (i_enable),
    .o_cnt   (o_hcnt),
    .o_state (h_state),
    .o_wrap  (h_wrap)
  );

  // The vertical axis steps on the same edge the horizontal count wraps,
  // so vertical state (and vsync) changes line up with hcnt = 0.
  assign v_step = i_enable & h_wrap;

  video_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .resetn  (resetn),
    .i_step  (v_step),
    .o_cnt   (o_vcnt),
    .o_state (v_state),
    .o_wrap  (v_wrap)
  );

  always_comb begin
    line_start_d  = v_step;
    frame_start_d = v_step & v_wrap;
    frame_cnt_d   = frame_cnt_q + 16'(frame_start_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Decoded straight from the state registers, so de/syncs track the counts
  // with no skew and hold whenever the states hold.
  assign o_de          = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
  assign o_hsync       = (h_state == ST_SYNC) ? HS_POL : ~HS_POL;
  assign o_vsync       = (v_state == ST_SYNC) ? VS_POL : ~VS_POL;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int unsigned HA  = 16;
  localparam int unsigned HFP = 4;
  localparam int unsigned HS  = 6;
  localparam int unsigned HBP = 6;
  localparam int unsigned VA  = 12;
  localparam int unsigned VFP = 2;
  localparam int unsigned VS  = 2;
  localparam int unsigned VBP = 3;
  localparam int unsigned HT  = HA + HFP + HS + HBP;
  localparam int unsigned VT  = VA + VFP + VS + VBP;
  localparam bit          HSP = 1'b1;
  localparam bit          VSP = 1'b0;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic i_enable = 1'b0;

  video_timing_gen_if vif ();

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .HS_POL   (HSP), .VS_POL (VSP)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_enable      (i_enable),
    .o_hcnt        (vif.hcnt),
    .o_vcnt        (vif.vcnt),
    .o_de          (vif.de),
    .o_hsync       (vif.hsync),
    .o_vsync       (vif.vsync),
    .o_line_start  (vif.line_start),
    .o_frame_start (vif.frame_start),
    .o_frame_cnt   (vif.frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference raster position and pulses.
  int unsigned mh = 0, mv = 0, mfc = 0;
  bit          mls = 1'b0, mfs = 1'b0;

  int unsigned total_chk = 0, pass_chk = 0, fail_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_chk++;
    assert (obs === exp) pass_chk++;
    else begin
      fail_chk++;
      $error("FAIL %s: observed %0h expected %0h (model h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  task automatic check_outputs();
    bit de, hs, vs;
    de = (mh < HA) && (mv < VA);
    hs = (mh >= HA + HFP && mh < HA + HFP + HS) ? HSP : !HSP;
    vs = (mv >= VA + VFP && mv < VA + VFP + VS) ? VSP : !VSP;
    chk("hcnt",        32'(vif.hcnt),        mh);
    chk("vcnt",        32'(vif.vcnt),        mv);
    chk("de",          32'(vif.de),          32'(de));
    chk("hsync",       32'(vif.hsync),       32'(hs));
    chk("vsync",       32'(vif.vsync),       32'(vs));
    chk("line_start",  32'(vif.line_start),  32'(mls));
    chk("frame_start", 32'(vif.frame_start), 32'(mfs));
    chk("frame_cnt",   32'(vif.frame_cnt),   mfc);
  endtask

  task automatic step(input bit en, input bit rn);
    i_enable = en;
    resetn   = rn;
    @(posedge clk);
    if (!rn) begin
      mh = HT - 1; mv = VT - 1; mfc = 0; mls = 0; mfs = 0;
    end else if (en) begin
      mh  = (mh + 1) % HT;
      if (mh == 0) mv = (mv + 1) % VT;
      mls = (mh == 0);
      mfs = mls && (mv == 0);
      if (mfs) mfc = (mfc + 1) & 32'hFFFF;
    end else begin
      mls = 0; mfs = 0;
    end
    #1;
    check_outputs();
  endtask

  task automatic advance_to(input int unsigned th, input int unsigned tv);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (mh == th && mv == tv) break;
      step(1'b1, 1'b1);
    end
    chk("reach_h", 32'(vif.hcnt), th);
    chk("reach_v", 32'(vif.vcnt), tv);
  endtask

  initial begin
    int unsigned n_de, n_hs, n_ls, n_vs;

    // Reset held with enable high: parked at the last pixel.
    repeat (3) step(1'b1, 1'b0);
    chk("rst_hcnt",  32'(vif.hcnt), HT - 1);
    chk("rst_vcnt",  32'(vif.vcnt), VT - 1);
    chk("rst_de",    32'(vif.de), 0);
    chk("rst_hsync", 32'(vif.hsync), 32'(!HSP));
    chk("rst_vsync", 32'(vif.vsync), 32'(!VSP));

    // First enabled edge after release.
    step(1'b1, 1'b1);
    chk("first_h",   32'(vif.hcnt), 0);
    chk("first_v",   32'(vif.vcnt), 0);
    chk("first_de",  32'(vif.de), 1);
    chk("first_ls",  32'(vif.line_start), 1);
    chk("first_fs",  32'(vif.frame_start), 1);
    chk("first_fc",  32'(vif.frame_cnt), 1);

    // One full line on line 0.
    n_de = 0; n_hs = 0; n_ls = 0;
    for (int i = 0; i < HT; i++) begin
      step(1'b1, 1'b1);
      if (vif.de === 1'b1) n_de++;
      if (vif.hsync === HSP) n_hs++;
      if (vif.line_start === 1'b1) n_ls++;
    end
    chk("line_de_cnt", n_de, HA);
    chk("line_hs_cnt", n_hs, HS);
    chk("line_ls_cnt", n_ls, 1);

    // Vsync entry at hcnt wrap and its exact length.
    advance_to(HT - 1, VA + VFP - 1);
    step(1'b1, 1'b1);
    chk("vs_entry_h", 32'(vif.hcnt), 0);
    chk("vs_entry",   32'(vif.vsync), 32'(VSP));
    n_vs = 0;
    for (int i = 0; i < 4 * HT * VS; i++) begin
      if (vif.vsync !== VSP) break;
      n_vs++;
      step(1'b1, 1'b1);
    end
    chk("vs_len",    n_vs, VS * HT);
    chk("vs_exit_h", 32'(vif.hcnt), 0);
    chk("vs_exit_v", 32'(vif.vcnt), VA + VFP + VS);

    // Frame wrap with the frame counter at its maximum.
    advance_to(HT - 1, VT - 1);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    mfc = 32'hFFFF;
    chk("fc_forced", 32'(vif.frame_cnt), 32'hFFFF);
    step(1'b1, 1'b1);
    chk("fc_wrap", 32'(vif.frame_cnt), 0);
    chk("fc_wrap_fs", 32'(vif.frame_start), 1);

    // Enable low for 7 cycles mid-line.
    advance_to(10, 3);
    repeat (7) begin
      step(1'b0, 1'b1);
      chk("hold_h",  32'(vif.hcnt), 10);
      chk("hold_ls", 32'(vif.line_start), 0);
    end
    step(1'b1, 1'b1);
    chk("resume_h", 32'(vif.hcnt), 11);

    // One-cycle reset mid-frame, then release.
    advance_to(20, 8);
    step(1'b1, 1'b0);
    chk("mid_rst_h",  32'(vif.hcnt), HT - 1);
    chk("mid_rst_v",  32'(vif.vcnt), VT - 1);
    chk("mid_rst_fc", 32'(vif.frame_cnt), 0);
    step(1'b1, 1'b1);
    chk("post_rst_fs", 32'(vif.frame_start), 1);

    // Randomized enable and occasional reset against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
    end

    $display("%0d/%0d checks passed", pass_chk, total_chk);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Free-running raster timing generator for the HDMI output path. It produces the pixel/line counters consumed by every sprite and overlay stage (ball, paddles, text). It also produces the sync, data-enable and frame/line marker signals consumed by the TMDS encoder stage. Counts are zero-based at the first visible pixel, so a consumer's `hcnt == 0 && vcnt == 0` test fires exactly once per frame, at the top-left active pixel.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync active level (0 = active-low)
- `VS_POL`, 0: vsync active level (0 = active-low)

Ports:
- `clk`  in  1  pixel clock
- `resetn`  in  1  synchronous, active-low reset
- `i_enable`  in  1  pixel-advance enable; when low, all state holds
- `o_hcnt`  out  11  horizontal count, 0..H_TOTAL-1
- `o_vcnt`  out  11  vertical count, 0..V_TOTAL-1
- `o_de`  out  1  active-video data enable
- `o_hsync`  out  1  horizontal sync at `HS_POL` level when active
- `o_vsync`  out  1  vertical sync at `VS_POL` level when active
- `o_line_start`  out  1  one-cycle pulse when `o_hcnt` becomes 0
- `o_frame_start`  out  1  one-cycle pulse when both counts become 0
- `o_frame_cnt`  out  16  frames started since reset, wrapping

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Both totals must be ≤ 2048. Elaboration fails otherwise.
- Per-axis state machine, states ACTIVE → FRONT → SYNC → BACK → ACTIVE:
  - ACTIVE covers counts [0, ACTIVE).
  - FRONT covers [ACTIVE, ACTIVE+FP).
  - SYNC covers [ACTIVE+FP, ACTIVE+FP+SYNC).
  - BACK covers the remainder up to TOTAL-1.
- The horizontal axis advances on every cycle with `i_enable` high.
- The vertical axis advances only on the cycle where hcnt wraps from H_TOTAL-1 to 0.
- Vertical state changes take effect at the same edge as the hcnt wrap, so vsync edges coincide with hcnt = 0.
- `o_de` = horizontal state is ACTIVE AND vertical state is ACTIVE.
- `o_hsync` is at `HS_POL` level only in horizontal SYNC state; `o_vsync` is at `VS_POL` level only in vertical SYNC state.
- `o_line_start` is high on the cycle where `o_hcnt` == 0 after an enabled advance.
- `o_frame_start` is high on the cycle where additionally `o_vcnt` == 0.
- `o_frame_cnt` increments by 1 on the same edge that asserts `o_frame_start`, wrapping 0xFFFF → 0x0000.
- `i_enable` low:
  - counters, states and `o_frame_cnt` hold;
  - `o_line_start` and `o_frame_start` are forced to 0;
  - `o_de`, `o_hsync` and `o_vsync` hold their values.
- Reset (`resetn` low at a clk edge), taking priority over `i_enable`:
  - `o_hcnt` = H_TOTAL-1 and `o_vcnt` = V_TOTAL-1;
  - both states BACK;
  - `o_de` = 0, syncs inactive;
  - pulses 0, `o_frame_cnt` = 0.
- Because reset parks the counters at the last pixel, counters never sit at (0,0) during reset. Downstream per-frame logic therefore does not advance during reset.
- Reset asserted mid-frame: the same values apply at the next edge. No partial line is completed.

## Timing
- All outputs are registered. Every output reflects the same raster position as `o_hcnt`/`o_vcnt` on the same cycle, with no skew between counts and sync/de.
- First enabled edge after reset release: `o_hcnt` = 0, `o_vcnt` = 0, `o_de` = 1, `o_line_start` = 1, `o_frame_start` = 1, `o_frame_cnt` = 1.
- Frame period: H_TOTAL × V_TOTAL enabled cycles (420000 by default).

## Structure
- Shared package `video_pkg` holds:
  - the axis state enum (ACTIVE, FRONT, SYNC, BACK);
  - default 640x480@60 timing constants;
  - a function computing TOTAL from the four segment lengths.
- Sub-module `video_axis_timer` is instantiated twice, for h and v. It takes parameters ACTIVE/FP/SYNC/BP and ports `clk`, `resetn`, `i_step`, and outputs `o_cnt`, `o_state`, `o_wrap`.
  - The h-instance `o_wrap` drives the v-instance `i_step`, gated with `i_enable`.
- The top level combines the two instances into de, sync, the pulses and the frame counter.

## Test plan
- Reset release with `i_enable` = 1 → first cycle shows hcnt = 0, vcnt = 0, de = 1, frame_start = 1, frame_cnt = 1. During reset, hcnt = 799, vcnt = 524, de = 0, hsync = vsync = 1.
- Scan line 0 → de = 1 for hcnt 0..639; hsync = 0 exactly for hcnt 656..751; line_start once per 800 cycles.
- hcnt 799 at vcnt 489 → next cycle hcnt = 0, vcnt = 490, vsync = 0. vsync stays 0 for exactly 1600 cycles and returns to 1 at hcnt = 0, vcnt = 492.
- Frame wrap at (799,524) → (0,0) with frame_start = 1. Force frame_cnt to 0xFFFF → it wraps to 0x0000 on that edge.
- Toggle `i_enable` low for 7 cycles mid-line at hcnt = 300 → hcnt holds at 300, pulses stay 0, and counting resumes at 301.
- Assert `resetn` low for 1 cycle at (400,200) → next cycle (799,524), de = 0, frame_cnt = 0. After release, (0,0) with frame_start = 1.
